// File: rtl/mem_stage_ctrl_if.sv
// Signal bundle between the MEM-stage controller and its surroundings: EX/MEM inputs,
// data-memory req/ack port, MEM/WB outputs and error flags.
interface mem_stage_ctrl_if;
  logic        in_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_wr_addr;
  logic        ex_reg_wr;
  logic        ex_mem_to_reg;
  logic        ex_mem_rd;
  logic        ex_mem_wr;

  logic        stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        wb_valid;
  logic        wb_reg_wr;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_wr_addr;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;

  logic        err_misalign;
  logic        err_timeout;

  modport master (
    input  in_valid, ex_alu_result, ex_store_data, ex_wr_addr, ex_reg_wr, ex_mem_to_reg,
           ex_mem_rd, ex_mem_wr, mem_rdata, mem_ack,
    output stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_reg_wr, wb_mem_to_reg,
           wb_wr_addr, wb_alu_result, wb_mem_data, err_misalign, err_timeout
  );

  modport slave (
    output in_valid, ex_alu_result, ex_store_data, ex_wr_addr, ex_reg_wr, ex_mem_to_reg,
           ex_mem_rd, ex_mem_wr, mem_rdata, mem_ack,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_reg_wr, wb_mem_to_reg,
           wb_wr_addr, wb_alu_result, wb_mem_data, err_misalign, err_timeout
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues load/store over a multi-cycle req/ack port, stalls upstream
// while waiting, and produces the registered MEM/WB bundle.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input logic              clk,
  input logic              rst_n,
  mem_stage_ctrl_if.master bus
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_wb_valid;
  logic              r_wb_reg_wr;
  logic              r_wb_mem_to_reg;
  logic [4:0]        r_wb_wr_addr;
  logic [31:0]       r_wb_alu_result;
  logic [31:0]       r_wb_mem_data;
  logic              r_err_misalign;
  logic              r_err_timeout;

  logic w_memop;
  logic w_aligned;
  logic w_last;
  logic w_stall;

  assign w_memop   = bus.in_valid & (bus.ex_mem_rd | bus.ex_mem_wr);
  assign w_aligned = (bus.ex_alu_result[1:0] == 2'b00);
  assign w_last    = (r_cnt == CNT_W'(TIMEOUT - 1));

  // The ack cycle and the final timeout cycle release upstream on the retiring edge.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      StIdle:  w_stall = w_memop & w_aligned;
      StWait:  w_stall = ~bus.mem_ack & ~w_last;
      default: w_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_cnt           <= '0;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_wb_valid      <= 1'b0;
      r_wb_reg_wr     <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_wr_addr    <= '0;
      r_wb_alu_result <= '0;
      r_wb_mem_data   <= '0;
      r_err_misalign  <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_wb_valid     <= 1'b0;
      r_err_misalign <= 1'b0;
      case (r_state)
        StIdle: begin
          if (!bus.in_valid) begin
            r_wb_reg_wr <= 1'b0;
          end else if (!w_memop) begin
            r_wb_valid      <= 1'b1;
            r_wb_reg_wr     <= bus.ex_reg_wr;
            r_wb_mem_to_reg <= bus.ex_mem_to_reg;
            r_wb_wr_addr    <= bus.ex_wr_addr;
            r_wb_alu_result <= bus.ex_alu_result;
            r_wb_mem_data   <= '0;
          end else if (!w_aligned) begin
            r_wb_valid      <= 1'b1;
            r_wb_reg_wr     <= 1'b0;
            r_wb_mem_to_reg <= bus.ex_mem_to_reg & ~bus.ex_mem_wr;
            r_wb_wr_addr    <= bus.ex_wr_addr;
            r_wb_alu_result <= bus.ex_alu_result;
            r_wb_mem_data   <= '0;
            r_err_misalign  <= 1'b1;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.ex_mem_wr;
            r_mem_addr  <= {bus.ex_alu_result[31:2], 2'b00};
            r_mem_wdata <= bus.ex_store_data;
            r_cnt       <= '0;
            r_wb_reg_wr <= 1'b0;
            r_state     <= StWait;
          end
        end
        StWait: begin
          // ex_* are still held upstream, so they describe the retiring entry.
          if (bus.mem_ack) begin
            r_mem_req       <= 1'b0;
            r_state         <= StIdle;
            r_wb_valid      <= 1'b1;
            r_wb_reg_wr     <= bus.ex_reg_wr;
            r_wb_mem_to_reg <= bus.ex_mem_to_reg & ~r_mem_we;
            r_wb_wr_addr    <= bus.ex_wr_addr;
            r_wb_alu_result <= bus.ex_alu_result;
            r_wb_mem_data   <= r_mem_we ? 32'h0 : bus.mem_rdata;
          end else if (w_last) begin
            r_mem_req       <= 1'b0;
            r_err_timeout   <= 1'b1;
            r_state         <= StIdle;
            r_wb_valid      <= 1'b1;
            r_wb_reg_wr     <= 1'b0;
            r_wb_mem_to_reg <= bus.ex_mem_to_reg & ~r_mem_we;
            r_wb_wr_addr    <= bus.ex_wr_addr;
            r_wb_alu_result <= bus.ex_alu_result;
            r_wb_mem_data   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.stall         = w_stall;
  assign bus.mem_req       = r_mem_req;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.wb_valid      = r_wb_valid;
  assign bus.wb_reg_wr     = r_wb_reg_wr;
  assign bus.wb_mem_to_reg = r_wb_mem_to_reg;
  assign bus.wb_wr_addr    = r_wb_wr_addr;
  assign bus.wb_alu_result = r_wb_alu_result;
  assign bus.wb_mem_data   = r_wb_mem_data;
  assign bus.err_misalign  = r_err_misalign;
  assign bus.err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios then randomized instructions, each checked
// against per-instruction expectations derived from the access rules.
module tb_mem_stage_ctrl;
  localparam int unsigned Timeout = 4;
  localparam int unsigned CntW    = 5;

  typedef struct {
    bit          valid;
    bit          rd;
    bit          wr;
    bit          reg_wr;
    bit          m2r;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] sd;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(
    .TIMEOUT(Timeout),
    .CNT_W  (CntW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_timeout = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input instr_t in);
    bus.in_valid      = in.valid;
    bus.ex_mem_rd     = in.rd;
    bus.ex_mem_wr     = in.wr;
    bus.ex_reg_wr     = in.reg_wr;
    bus.ex_mem_to_reg = in.m2r;
    bus.ex_wr_addr    = in.wa;
    bus.ex_alu_result = in.alu;
    bus.ex_store_data = in.sd;
  endtask

  // Called at edge+1 of an IDLE cycle; returns at edge+1 of the retirement cycle.
  // lat: request cycle (1..Timeout) carrying the ack, 0 = never acked.
  task automatic run_instr(input instr_t in, input int lat, input bit stray_ack,
                           input logic [31:0] ack_data);
    bit          memop;
    bit          aligned;
    int          n;
    logic [31:0] rdata;
    memop   = in.valid && (in.rd || in.wr);
    aligned = (in.alu[1:0] == 2'b00);
    rdata   = '0;
    drive(in);
    bus.mem_ack   = stray_ack;
    bus.mem_rdata = $urandom;
    #1 check_eq("stall_issue", {31'b0, bus.stall}, {31'b0, memop && aligned});
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    if (memop && aligned) begin
      n = (lat == 0) ? Timeout : lat;
      for (int j = 1; j <= n; j++) begin
        check_eq("mem_req", {31'b0, bus.mem_req}, 32'd1);
        check_eq("mem_we", {31'b0, bus.mem_we}, {31'b0, in.wr});
        check_eq("mem_addr", bus.mem_addr, {in.alu[31:2], 2'b00});
        if (in.wr) check_eq("mem_wdata", bus.mem_wdata, in.sd);
        check_eq("wb_valid_wait", {31'b0, bus.wb_valid}, 32'd0);
        bus.mem_ack   = (j == lat);
        bus.mem_rdata = (j == lat) ? ack_data : $urandom;
        if (j == lat) rdata = ack_data;
        #1 check_eq("stall_wait", {31'b0, bus.stall}, {31'b0, j != n});
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
      end
      if (lat == 0) exp_timeout = 1'b1;
    end
    check_eq("mem_req_retire", {31'b0, bus.mem_req}, 32'd0);
    check_eq("err_misalign", {31'b0, bus.err_misalign}, {31'b0, memop && !aligned});
    check_eq("err_timeout", {31'b0, bus.err_timeout}, {31'b0, exp_timeout});
    if (!in.valid) begin
      check_eq("wb_valid_idle", {31'b0, bus.wb_valid}, 32'd0);
      check_eq("wb_reg_wr_idle", {31'b0, bus.wb_reg_wr}, 32'd0);
    end else begin
      check_eq("wb_valid", {31'b0, bus.wb_valid}, 32'd1);
      if (!memop) begin
        check_eq("wb_reg_wr", {31'b0, bus.wb_reg_wr}, {31'b0, in.reg_wr});
        check_eq("wb_m2r", {31'b0, bus.wb_mem_to_reg}, {31'b0, in.m2r});
        check_eq("wb_wr_addr", {27'b0, bus.wb_wr_addr}, {27'b0, in.wa});
        check_eq("wb_alu", bus.wb_alu_result, in.alu);
        check_eq("wb_mem_data", bus.wb_mem_data, 32'd0);
      end else if (!aligned || lat == 0) begin
        check_eq("wb_reg_wr_err", {31'b0, bus.wb_reg_wr}, 32'd0);
        check_eq("wb_mem_data_err", bus.wb_mem_data, 32'd0);
      end else begin
        check_eq("wb_reg_wr_mem", {31'b0, bus.wb_reg_wr}, {31'b0, in.reg_wr});
        check_eq("wb_m2r_mem", {31'b0, bus.wb_mem_to_reg}, {31'b0, in.m2r && !in.wr});
        check_eq("wb_wr_addr_mem", {27'b0, bus.wb_wr_addr}, {27'b0, in.wa});
        check_eq("wb_alu_mem", bus.wb_alu_result, in.alu);
        check_eq("wb_mem_data_mem", bus.wb_mem_data, in.wr ? 32'd0 : rdata);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_req"}, {31'b0, bus.mem_req}, 32'd0);
    check_eq({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
    check_eq({tag, "_wb_valid"}, {31'b0, bus.wb_valid}, 32'd0);
    check_eq({tag, "_wb_reg_wr"}, {31'b0, bus.wb_reg_wr}, 32'd0);
    check_eq({tag, "_wb_alu"}, bus.wb_alu_result, 32'd0);
    check_eq({tag, "_wb_mem_data"}, bus.wb_mem_data, 32'd0);
    check_eq({tag, "_err_timeout"}, {31'b0, bus.err_timeout}, 32'd0);
    check_eq({tag, "_stall"}, {31'b0, bus.stall}, 32'd0);
  endtask

  instr_t ins;

  initial begin
    ins = '{valid: 1'b0, rd: 1'b0, wr: 1'b0, reg_wr: 1'b0, m2r: 1'b0, wa: 5'd0,
            alu: 32'd0, sd: 32'd0};
    drive(ins);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    #3 check_all_zero("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a pending load.
    ins = '{valid: 1'b1, rd: 1'b1, wr: 1'b0, reg_wr: 1'b1, m2r: 1'b1, wa: 5'd3,
            alu: 32'h200, sd: 32'd0};
    drive(ins);
    @(posedge clk); #1;
    check_eq("pre_reset_req", {31'b0, bus.mem_req}, 32'd1);
    ins.valid = 1'b0;
    drive(ins);
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check_eq("stray_ack_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    check_eq("stray_ack_req", {31'b0, bus.mem_req}, 32'd0);

    // ALU pass-through.
    ins = '{valid: 1'b1, rd: 1'b0, wr: 1'b0, reg_wr: 1'b1, m2r: 1'b0, wa: 5'd9,
            alu: 32'h42, sd: 32'd0};
    run_instr(ins, 0, 1'b0, 32'd0);
    // Load acked in the third request cycle.
    ins = '{valid: 1'b1, rd: 1'b1, wr: 1'b0, reg_wr: 1'b1, m2r: 1'b1, wa: 5'd4,
            alu: 32'h100, sd: 32'd0};
    run_instr(ins, 3, 1'b0, 32'hDEAD_BEEF);
    // Store acked immediately.
    ins = '{valid: 1'b1, rd: 1'b0, wr: 1'b1, reg_wr: 1'b0, m2r: 1'b0, wa: 5'd0,
            alu: 32'h10, sd: 32'h1234_5678};
    run_instr(ins, 1, 1'b0, 32'hFFFF_FFFF);
    // Misaligned load.
    ins = '{valid: 1'b1, rd: 1'b1, wr: 1'b0, reg_wr: 1'b1, m2r: 1'b1, wa: 5'd5,
            alu: 32'h102, sd: 32'd0};
    run_instr(ins, 1, 1'b0, 32'd0);
    // Timeout, then a normal ALU op.
    ins = '{valid: 1'b1, rd: 1'b1, wr: 1'b0, reg_wr: 1'b1, m2r: 1'b1, wa: 5'd6,
            alu: 32'h300, sd: 32'd0};
    run_instr(ins, 0, 1'b0, 32'd0);
    ins = '{valid: 1'b1, rd: 1'b0, wr: 1'b0, reg_wr: 1'b1, m2r: 1'b0, wa: 5'd7,
            alu: 32'h77, sd: 32'd0};
    run_instr(ins, 0, 1'b0, 32'd0);

    for (int k = 0; k < 300; k++) begin
      ins.valid  = ($urandom_range(0, 9) != 0);
      ins.rd     = 1'($urandom_range(0, 1));
      ins.wr     = 1'($urandom_range(0, 1));
      ins.reg_wr = 1'($urandom_range(0, 1));
      ins.m2r    = 1'($urandom_range(0, 1));
      ins.wa     = 5'($urandom);
      ins.alu    = $urandom;
      ins.sd     = $urandom;
      if ($urandom_range(0, 3) != 0) ins.alu[1:0] = 2'b00;
      run_instr(ins, int'($urandom_range(0, Timeout)), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
